mips_store_write_buffer: RTL and testbench

MIPS_STORE_WRITE_BUFFER -- requirements
Module: mips_store_write_buffer

---
 rtl/mips_store_write_buffer.sv | 113 +++++++++++
 tb/tb_mips_store_write_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_store_write_buffer.sv
// Posted-store write buffer between a MIPS core and data memory: FIFO of {addr, data} drained
// one write at a time. Define MIPS_WB_LOAD_FWD_EN to build in store-to-load forwarding.
module mips_store_write_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_hit,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  wb_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  push, pop;

  assign st_ready = (count_q != CntW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == StWrite) && mem_ack;
  assign mem_req  = (state_q == StWrite);
  assign wb_empty = (count_q == '0) && (state_q == StIdle);

  // Gated so the memory port reads zero whenever no write is in flight.
  assign mem_addr  = mem_req ? addr_q[rd_ptr_q] : '0;
  assign mem_wdata = mem_req ? data_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    unique case (state_q)
      StIdle:  if (count_d != '0) state_d = StWrite;
      StWrite: if (pop && (count_d == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  logic unused_ld;
  assign unused_ld = ^ld_addr;

`ifdef MIPS_WB_LOAD_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) &&
          (addr_q[fwd_idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end
`else
  assign ld_hit  = 1'b0;
  assign ld_data = '0;
`endif

endmodule

// File: tb/tb_mips_store_write_buffer.sv
// Directed bench for mips_store_write_buffer (DEPTH = 4): drain latency, full/back-pressure,
// pointer wrap, forwarding (when MIPS_WB_LOAD_FWD_EN is defined) and reset of an active write.
module tb_mips_store_write_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        wb_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mips_store_write_buffer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (4)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .wb_empty (wb_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    ld_addr  = 32'h0;
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_ld_hit", 32'(ld_hit), 32'd0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_wb_empty", 32'(wb_empty), 32'd1);

    // Single store with mem_ack held high.
    mem_ack  = 1'b1;
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 32'hA5A5A5A5;
    tick();
    st_valid = 1'b0;
    #1;
    check("one_mem_req", 32'(mem_req), 32'd1);
    check("one_mem_addr", mem_addr, 32'h10);
    check("one_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    check("one_wb_empty_busy", 32'(wb_empty), 32'd0);
    tick();
    check("one_mem_req_done", 32'(mem_req), 32'd0);
    check("one_wb_empty", 32'(wb_empty), 32'd1);
    mem_ack = 1'b0;

    // Five back-to-back stores, no acks: the fifth must be refused.
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h100 + 32'(4 * i);
      st_data  = 32'h1000 + 32'(i);
      #1;
      check($sformatf("fill_st_ready_%0d", i), 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    st_valid = 1'b0;
    #1;
    check("full_st_ready", 32'(st_ready), 32'd0);
    check("full_mem_req", 32'(mem_req), 32'd1);
    check("full_mem_addr", mem_addr, 32'h100);
    tick();
    tick();
    check("full_mem_addr_held", mem_addr, 32'h100);
    check("full_mem_wdata_held", mem_wdata, 32'h1000);

    // One ack pulse with a store waiting: ready rises only the cycle after the pop.
    mem_ack  = 1'b1;
    st_valid = 1'b1;
    st_addr  = 32'h200;
    st_data  = 32'h2000;
    #1;
    check("pulse_st_ready_same", 32'(st_ready), 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("pulse_st_ready_next", 32'(st_ready), 32'd1);
    check("pulse_mem_addr_next", mem_addr, 32'h104);
    tick();
    st_valid = 1'b0;
    #1;
    check("pulse_st_ready_refull", 32'(st_ready), 32'd0);

    // Drain across the pointer wrap in FIFO order.
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea, ed;
      ea = (i < 3) ? 32'h104 + 32'(4 * i) : 32'h200;
      ed = (i < 3) ? 32'h1001 + 32'(i) : 32'h2000;
      check($sformatf("drain_req_%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("drain_addr_%0d", i), mem_addr, ea);
      check($sformatf("drain_data_%0d", i), mem_wdata, ed);
      tick();
    end
    check("drain_mem_req_off", 32'(mem_req), 32'd0);
    check("drain_wb_empty", 32'(wb_empty), 32'd1);
    mem_ack = 1'b0;

    // Two stores to the same word, then a third, all held pending.
    st_valid = 1'b1;
    st_addr  = 32'h20;
    st_data  = 32'd1;
    tick();
    st_data = 32'd2;
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h22;
    #1;
`ifdef MIPS_WB_LOAD_FWD_EN
    check("fwd_hit", 32'(ld_hit), 32'd1);
    check("fwd_data_youngest", ld_data, 32'd2);
    ld_addr = 32'h24;
    #1;
    check("fwd_miss", 32'(ld_hit), 32'd0);
`else
    check("nofwd_hit", 32'(ld_hit), 32'd0);
    check("nofwd_data", ld_data, 32'd0);
`endif
    st_valid = 1'b1;
    st_addr  = 32'h28;
    st_data  = 32'd3;
    tick();
    st_valid = 1'b0;
    #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    check("pre_rst_mem_addr", mem_addr, 32'h20);

    // Reset during WRITE, competing with a store and an ack.
    RST      = 1'b1;
    st_valid = 1'b1;
    st_addr  = 32'h30;
    st_data  = 32'd4;
    mem_ack  = 1'b1;
    tick();
    RST      = 1'b0;
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    ld_addr  = 32'h22;
    #1;
    check("rst_wr_mem_req", 32'(mem_req), 32'd0);
    check("rst_wr_wb_empty", 32'(wb_empty), 32'd1);
    check("rst_wr_st_ready", 32'(st_ready), 32'd1);
    check("rst_wr_mem_addr", mem_addr, 32'h0);
    check("rst_wr_ld_hit", 32'(ld_hit), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_wr_quiet_%0d", i), 32'(mem_req), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
